// File: rtl/fifo_wr_source.sv
// rtl/fifo_wr_source.sv - write-domain burst pattern producer for the async FIFO
module fifo_wr_source #(
  parameter int D_SIZE  = 16,
  parameter int LEN_W   = 8,
  parameter int STALL_W = 16
) (
  input  logic               w_clk,
  input  logic               i_w_rstn,
  input  logic               i_start,
  input  logic [LEN_W-1:0]   i_len,
  input  logic               i_mode,
  input  logic [D_SIZE-1:0]  i_seed,
  input  logic               i_full,
  output logic               o_w_inc,
  output logic [D_SIZE-1:0]  o_w_data,
  output logic               o_busy,
  output logic               o_done,
  output logic [LEN_W-1:0]   o_wr_count,
  output logic [STALL_W-1:0] o_stall_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [LEN_W-1:0]    wr_count_q, wr_count_d;
  logic                mode_q, mode_d;
  logic [D_SIZE-1:0]   data_q, data_d;
  logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                accept;
  logic [D_SIZE-1:0]   lfsr_next;

  // Write request is combinational on i_full so a full FIFO never sees a write.
  assign accept    = (state_q == S_BURST) && !i_full;
  assign lfsr_next = {data_q[D_SIZE-2:0],
                      data_q[D_SIZE-1] ^ data_q[D_SIZE-3] ^ data_q[D_SIZE-4] ^ data_q[D_SIZE-6]};

  assign o_w_inc     = accept;
  assign o_w_data    = data_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_wr_count  = wr_count_q;
  assign o_stall_cnt = stall_cnt_q;

  // Next-state and datapath: load on start, advance on accept, count stalls.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    wr_count_d  = wr_count_q;
    mode_d      = mode_q;
    data_d      = data_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          wr_count_d  = '0;
          stall_cnt_d = '0;
          if (i_len != '0) begin
            state_d = S_BURST;
            rem_d   = i_len;
            mode_d  = i_mode;
            // An all-zero seed would lock the LFSR, so substitute 1.
            data_d  = (i_mode && (i_seed == '0)) ? D_SIZE'(1) : i_seed;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_BURST: begin
        if (accept) begin
          data_d     = mode_q ? lfsr_next : data_q + D_SIZE'(1);
          rem_d      = rem_q - LEN_W'(1);
          wr_count_d = wr_count_q + LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = S_DONE;
          end
        end else if (stall_cnt_q != '1) begin
          stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_BURST);
    done_d = (state_d == S_DONE);
  end

  // State and registered outputs; reset is asynchronous and active-high.
  always_ff @(posedge w_clk or posedge i_w_rstn) begin
    if (i_w_rstn) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      wr_count_q  <= '0;
      mode_q      <= 1'b0;
      data_q      <= '0;
      stall_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      wr_count_q  <= wr_count_d;
      mode_q      <= mode_d;
      data_q      <= data_d;
      stall_cnt_q <= stall_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_source.sv
// tb/tb_fifo_wr_source.sv - bench for fifo_wr_source
module tb_fifo_wr_source;

  logic        w_clk;
  logic        i_w_rstn;
  logic        i_start;
  logic [7:0]  i_len;
  logic        i_mode;
  logic [15:0] i_seed;
  logic        i_full;
  logic        o_w_inc;
  logic [15:0] o_w_data;
  logic        o_busy;
  logic        o_done;
  logic [7:0]  o_wr_count;
  logic [15:0] o_stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_wr_source #(.D_SIZE(16), .LEN_W(8), .STALL_W(16)) dut (
    .w_clk       (w_clk),
    .i_w_rstn    (i_w_rstn),
    .i_start     (i_start),
    .i_len       (i_len),
    .i_mode      (i_mode),
    .i_seed      (i_seed),
    .i_full      (i_full),
    .o_w_inc     (o_w_inc),
    .o_w_data    (o_w_data),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_wr_count  (o_wr_count),
    .o_stall_cnt (o_stall_cnt)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  typedef struct {
    int          len;
    bit          mode;
    logic [15:0] seed;
    int          fpat;       // 0 never full, 1 full on even cycles, 2 random, 3 full x5 after 2nd write
    int          exp_stall;  // -1: take the model's count
    int          restart_at; // cycle to pulse a stray i_start, 0 = none
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] next_word(input logic [15:0] d, input bit m);
    if (!m) return d + 16'd1;
    return {d[14:0], d[15] ^ d[13] ^ d[12] ^ d[10]};
  endfunction

  task automatic run_burst(input int len, input bit mode, input logic [15:0] seed,
                           input int fpat, input int exp_stall, input int restart_at);
    logic [15:0] w;
    int  acc, stall, hold;
    bit  full, active, done_seen;
    w = (mode && seed == 16'h0) ? 16'h0001 : seed;
    acc = 0; stall = 0; hold = 0; done_seen = 0;
    @(posedge w_clk); #1;
    i_start = 1'b1; i_len = 8'(len); i_mode = mode; i_seed = seed; i_full = 1'b0;
    @(posedge w_clk); #1;
    i_start = 1'b0; i_len = 8'($urandom); i_seed = 16'($urandom);
    for (int cyc = 1; cyc <= 300 && !done_seen; cyc++) begin
      active = (acc < len);
      case (fpat)
        1:       full = (cyc % 2 == 0);
        2:       full = ($urandom % 2) == 1;
        3:       full = (acc == 2) && (hold < 5);
        default: full = 1'b0;
      endcase
      i_full  = full;
      i_start = (restart_at == cyc);
      @(negedge w_clk);
      if (cyc == 1) chk("wr_count_start", o_wr_count, 0);
      chk("w_inc", o_w_inc, active && !full);
      chk("busy", o_busy, active);
      if (active && !full) chk("w_data", o_w_data, w);
      if (!active) begin
        chk("done_pulse", o_done, 1);
        done_seen = 1;
      end else begin
        chk("done_low", o_done, 0);
      end
      if (active) begin
        if (full) begin
          stall++;
          if (fpat == 3) hold++;
        end else begin
          acc++;
          w = next_word(w, mode);
        end
      end
      @(posedge w_clk); #1;
    end
    i_start = 1'b0;
    i_full  = 1'b0;
    if (!done_seen) begin
      n_checks++; n_fail++;
      $display("FAIL burst_timeout: got no o_done expected done within 300 cycles");
    end
    @(negedge w_clk);
    chk("done_single", o_done, 0);
    chk("busy_after", o_busy, 0);
    chk("wr_count_final", o_wr_count, len);
    chk("stall_final", o_stall_cnt, (exp_stall < 0) ? stall : exp_stall);
  endtask

  initial begin
    tbl[0] = '{4, 1'b0, 16'h00FE, 0, 0, 0};
    tbl[1] = '{3, 1'b1, 16'h0000, 0, 0, 0};
    tbl[2] = '{6, 1'b0, 16'h0000, 3, 5, 0};
    tbl[3] = '{0, 1'b0, 16'h1234, 0, 0, 0};
    tbl[4] = '{8, 1'b0, 16'h0040, 0, 0, 3};
    tbl[5] = '{5, 1'b0, 16'hFFFE, 1, 4, 0};
    tbl[6] = '{8, 1'b1, 16'hACE1, 1, 7, 0};

    i_w_rstn = 1'b1; i_start = 1'b0; i_len = 8'h0; i_mode = 1'b0;
    i_seed = 16'h0; i_full = 1'b0;
    repeat (3) @(posedge w_clk);
    @(negedge w_clk);
    chk("rst_w_inc", o_w_inc, 0);
    chk("rst_w_data", o_w_data, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_wr_count", o_wr_count, 0);
    chk("rst_stall", o_stall_cnt, 0);
    @(posedge w_clk); #1;
    i_w_rstn = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge w_clk);
      chk("idle_w_inc", o_w_inc, 0);
      chk("idle_busy", o_busy, 0);
      chk("idle_done", o_done, 0);
    end

    for (int t = 0; t < 7; t++)
      run_burst(tbl[t].len, tbl[t].mode, tbl[t].seed, tbl[t].fpat, tbl[t].exp_stall, tbl[t].restart_at);

    // Reset mid-burst: abort after the 3rd accepted write, no done pulse.
    @(posedge w_clk); #1;
    i_start = 1'b1; i_len = 8'd10; i_mode = 1'b0; i_seed = 16'h0100; i_full = 1'b0;
    @(posedge w_clk); #1;
    i_start = 1'b0;
    repeat (3) @(posedge w_clk);
    @(negedge w_clk);
    chk("pre_abort_w_inc", o_w_inc, 1);
    chk("pre_abort_data", o_w_data, 16'h0103);
    #2 i_w_rstn = 1'b1;
    #1;
    chk("abort_w_inc", o_w_inc, 0);
    chk("abort_busy", o_busy, 0);
    chk("abort_wr_count", o_wr_count, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge w_clk);
      chk("abort_no_done", o_done, 0);
    end
    @(posedge w_clk); #1;
    i_w_rstn = 1'b0;
    @(negedge w_clk);
    chk("post_abort_done", o_done, 0);
    run_burst(3, 1'b0, 16'h0010, 0, 0, 0);

    for (int r = 0; r < 20; r++)
      run_burst($urandom_range(0, 12), 1'($urandom), 16'($urandom), 2, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_source.md
Name: fifo_wr_source

Overview:
- Write-domain producer for the async FIFO. Generates bursts of pattern data into the FIFO write port (i_w_inc/i_w_data/o_full side) and honours back-pressure from o_full.
- Pairs with a read-domain checker at the other end. Used in block-level benches and in on-chip BIST of the FIFO.
- Bursts are command-driven: start pulse, length, mode and seed. The block reports progress, stall cycles and completion.

Parameters:
- D_SIZE, 16, FIFO data width. The LFSR mode is maximal-length only at 16.
- LEN_W, 8, width of the burst length and word counter.
- STALL_W, 16, width of the saturating stall counter.

Ports:
- w_clk  in  1  write-domain clock
- i_w_rstn  in  1  reset, asynchronous, active-high. Despite the _n suffix, a level of 1 holds the block in reset.
- i_start  in  1  burst start request, sampled in IDLE only
- i_len  in  LEN_W  burst length in words, sampled with i_start
- i_mode  in  1  0 = incrementing pattern, 1 = LFSR pattern
- i_seed  in  D_SIZE  first data word, sampled with i_start
- i_full  in  1  FIFO o_full (registered in the write domain)
- o_w_inc  out  1  write request to FIFO i_w_inc
- o_w_data  out  D_SIZE  write data to FIFO i_w_data
- o_busy  out  1  high while in BURST
- o_done  out  1  one-cycle completion pulse
- o_wr_count  out  LEN_W  words accepted in the current or last burst
- o_stall_cnt  out  STALL_W  cycles in BURST with i_full=1, saturating

Behaviour:
- Reset (i_w_rstn=1, asynchronous) clears everything: state=IDLE, o_w_inc=0, o_w_data=0, o_busy=0, o_done=0, o_wr_count=0, o_stall_cnt=0. The remaining-words register also clears.
- States: IDLE, BURST, DONE.

IDLE:
- i_start=1 with i_len!=0 goes to BURST next edge and loads:
  - remaining=i_len, mode=i_mode
  - o_w_data=i_seed, except in LFSR mode with i_seed=0, where 1 is loaded instead
  - o_wr_count=0, o_stall_cnt=0
- i_start=1 with i_len=0 goes to DONE (zero-length burst). Counters clear and nothing is written.

BURST:
- o_w_inc = (state==BURST) && !i_full. This is combinational on i_full, so no write is ever issued while full.
- Accept = o_w_inc. On each accept at a posedge:
  - o_w_data advances: +1 mod 2^D_SIZE in incrementing mode, LFSR step in LFSR mode.
  - remaining decrements and o_wr_count increments.
- If accept happens with remaining==1, go to DONE.
- A cycle in BURST with i_full=1 increments o_stall_cnt, saturating at all-ones. The data word is held stable until accepted.

LFSR step:
- data <= {data[D_SIZE-2:0], fb}, where fb = data[D_SIZE-1]^data[D_SIZE-3]^data[D_SIZE-4]^data[D_SIZE-6].

DONE:
- o_done=1 for exactly one cycle, then return to IDLE.
- o_wr_count and o_stall_cnt hold their values until the next start.

Other rules:
- i_start outside IDLE is ignored; it is neither queued nor allowed to restart.
- Latency: first o_w_inc is asserted 1 cycle after i_start is sampled, if not full. With i_full=0 throughout, a burst of N takes N+2 cycles from start to the o_done pulse.
- i_full toggling every cycle: writes are issued only on not-full cycles. No word is skipped or duplicated.
- Reset mid-burst: immediate abort, o_w_inc drops asynchronously, no o_done pulse.
- Wrap: the incrementing pattern wraps FFFF->0000. o_wr_count never exceeds i_len, so it cannot overflow.

Test Plan:
- Reset held, then released with no start → all outputs 0, state IDLE, o_w_inc never asserted.
- i_start, i_len=4, i_mode=0, i_seed=16'h00FE, i_full=0 → writes 00FE, 00FF, 0100, 0101 on 4 consecutive cycles. o_done pulses 1 cycle after the last write; o_wr_count=4, o_stall_cnt=0.
- i_len=3, i_mode=1, i_seed=0, i_full=0 → writes 0001, 0002, 0004. o_wr_count=3.
- i_len=6, incrementing from 0, i_full high for 5 cycles after the 2nd write → exactly 6 writes 0..5. o_w_inc=0 during the full cycles, o_stall_cnt=5, data holds 0002 while stalled.
- i_start with i_len=0 → o_done pulse 1 cycle after the start is sampled, no o_w_inc, o_wr_count=0. A second i_start during BURST of a len=8 burst is ignored, so exactly 8 writes occur.
- Reset asserted after the 3rd write of a len=10 burst → o_w_inc drops immediately, no o_done. A new burst after release starts clean, with o_wr_count starting from 0.
